// File: rtl/cmos_ctrl_pkg.sv
// Shared types and defaults for the dual-camera source switch controller.
// The state encoding and default timing parameters are kept here so the top and the bench agree on them.
package cmos_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_EOF = 2'd1,
        ST_SWAP     = 2'd2,
        ST_WAIT_SOF = 2'd3
    } ctrl_state_t;

    localparam int DEF_DB_CNT      = 65535;
    localparam int DEF_AUTO_FRAMES = 30;
    localparam int DEF_TIMEOUT     = 16777215;

    // Slots in the synchronizer bank
    localparam int SYNC_KEY   = 0;
    localparam int SYNC_CMOS1 = 1;
    localparam int SYNC_CMOS2 = 2;
    localparam int NUM_SYNC   = 3;

    // Bits needed to hold 0..max_val, never less than one
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cmos_edge_sync.sv
// Two-flop synchronizer for one asynchronous input, plus a one-cycle pulse on
// each rising edge of the synchronized level.
module cmos_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic sync_d_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            sync_d_reg <= 1'b0;
        end else begin
            meta_reg   <= din;
            sync_reg   <= meta_reg;
            sync_d_reg <= sync_reg;
        end
    end

    assign dout = sync_reg;
    assign rise = sync_reg & ~sync_d_reg;

endmodule

// File: rtl/cmos_switch_ctrl.sv
// Selects between two camera streams, swapping only on frame boundaries so the
// frame writer never sees a torn frame. Swaps come from a debounced key or from auto alternation.
module cmos_switch_ctrl
    import cmos_ctrl_pkg::*;
#(
    parameter int DB_CNT      = DEF_DB_CNT,
    parameter int AUTO_FRAMES = DEF_AUTO_FRAMES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key1,
    input  logic       auto_en,
    input  logic       cmos1_vsync,
    input  logic       cmos2_vsync,
    output logic       sel,
    output logic       out_valid,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] switch_cnt
);

    localparam int DB_W = cnt_width(DB_CNT);
    localparam int TO_W = cnt_width(TIMEOUT);
    localparam int FR_W = cnt_width(AUTO_FRAMES);

    localparam logic [DB_W-1:0] DB_MAX     = DB_W'(DB_CNT);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CNT - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam bit              AUTO_ON    = (AUTO_FRAMES > 0);
    localparam logic [FR_W-1:0] FRAME_LAST = AUTO_ON ? FR_W'(AUTO_FRAMES - 1) : '0;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [NUM_SYNC-1:0] async_in;
    logic [NUM_SYNC-1:0] sync_level;
    logic [NUM_SYNC-1:0] sync_rise;

    assign async_in = {cmos2_vsync, cmos1_vsync, key1};

    generate
        for (genvar gi = 0; gi < NUM_SYNC; gi++) begin : g_sync
            cmos_edge_sync u_sync (
                .clk   (clk),
                .reset (reset),
                .din   (async_in[gi]),
                .dout  (sync_level[gi]),
                .rise  (sync_rise[gi])
            );
        end
    endgenerate

    logic key_sync;
    logic cmos1_rise;
    logic cmos2_rise;

    assign key_sync   = sync_level[SYNC_KEY];
    assign cmos1_rise = sync_rise[SYNC_CMOS1];
    assign cmos2_rise = sync_rise[SYNC_CMOS2];

    // Key release edges and raw vsync levels carry no information for this block
    logic unused_sync_bits;
    assign unused_sync_bits = ^{sync_rise[SYNC_KEY], sync_level[SYNC_CMOS1], sync_level[SYNC_CMOS2]};

    // ------------------------------------------------------------------
    // Key debounce: one press pulse per continuous hold of DB_CNT cycles
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_reg;
    logic            press_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_reg <= '0;
            press_reg  <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            if (key_sync) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg != DB_MAX) begin
                db_cnt_reg <= db_cnt_reg + DB_W'(1);
                press_reg  <= (db_cnt_reg == DB_LAST);
            end
        end
    end

    // ------------------------------------------------------------------
    // Auto alternation: count frames of the live source while running
    // ------------------------------------------------------------------
    ctrl_state_t     state_reg;
    logic            sel_reg;
    logic            sel_rise;
    logic [FR_W-1:0] frame_cnt_reg;
    logic            auto_req;
    logic            auto_active;

    assign sel_rise    = sel_reg ? cmos1_rise : cmos2_rise;
    assign auto_active = AUTO_ON && auto_en && (state_reg == ST_RUN);

    always_comb begin
        auto_req = 1'b0;
        if (auto_active && sel_rise && (frame_cnt_reg == FRAME_LAST)) begin
            auto_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= '0;
        end else if (!auto_active) begin
            frame_cnt_reg <= '0;
        end else if (sel_rise) begin
            frame_cnt_reg <= auto_req ? '0 : frame_cnt_reg + FR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Switch sequencer
    // ------------------------------------------------------------------
    logic            req;
    logic            to_expired;
    logic [TO_W-1:0] to_cnt_reg;
    logic            out_valid_reg;
    logic            busy_reg;
    logic            timeout_err_reg;
    logic [7:0]      switch_cnt_reg;

    // A key press and an auto request landing together collapse into one switch
    assign req        = press_reg | auto_req;
    assign to_expired = (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            sel_reg         <= 1'b0;
            out_valid_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            switch_cnt_reg  <= '0;
            to_cnt_reg      <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
            unique case (state_reg)
                ST_RUN: begin
                    to_cnt_reg <= '0;
                    if (req) begin
                        state_reg <= ST_WAIT_EOF;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_WAIT_EOF: begin
                    // A real edge wins over an expiry in the same cycle
                    if (sel_rise || to_expired) begin
                        state_reg     <= ST_SWAP;
                        out_valid_reg <= 1'b0;
                        to_cnt_reg    <= '0;
                        if (!sel_rise) begin
                            timeout_err_reg <= 1'b1;
                        end
                    end
                end
                ST_SWAP: begin
                    sel_reg    <= ~sel_reg;
                    state_reg  <= ST_WAIT_SOF;
                    to_cnt_reg <= '0;
                end
                ST_WAIT_SOF: begin
                    if (sel_rise || to_expired) begin
                        state_reg      <= ST_RUN;
                        out_valid_reg  <= 1'b1;
                        busy_reg       <= 1'b0;
                        switch_cnt_reg <= switch_cnt_reg + 8'd1;
                        if (!sel_rise) begin
                            timeout_err_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign sel         = sel_reg;
    assign out_valid   = out_valid_reg;
    assign busy        = busy_reg;
    assign timeout_err = timeout_err_reg;
    assign switch_cnt  = switch_cnt_reg;

endmodule

// File: tb/tb_cmos_switch_ctrl.sv
// Bench for cmos_switch_ctrl: a cycle-level reference model checked every clock,
// plus directed scenarios with hand-computed timing.
`timescale 1ns/1ps
module tb_cmos_switch_ctrl;

    localparam int DB_CNT      = 16;
    localparam int AUTO_FRAMES = 3;
    localparam int TIMEOUT     = 64;

    localparam int PH_RUN  = 0;
    localparam int PH_EOF  = 1;
    localparam int PH_SWAP = 2;
    localparam int PH_SOF  = 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       key1    = 1'b1;
    logic       auto_en = 1'b0;
    logic       v1_man  = 1'b0;
    logic       v2_man  = 1'b0;
    logic       v1_gen  = 1'b0;
    logic       v2_gen  = 1'b0;
    logic       gen_en  = 1'b0;
    logic       cmos1_vsync;
    logic       cmos2_vsync;
    logic       sel;
    logic       out_valid;
    logic       busy;
    logic       timeout_err;
    logic [7:0] switch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    assign cmos1_vsync = gen_en ? v1_gen : v1_man;
    assign cmos2_vsync = gen_en ? v2_gen : v2_man;

    always #5 clk = ~clk;

    cmos_switch_ctrl #(
        .DB_CNT      (DB_CNT),
        .AUTO_FRAMES (AUTO_FRAMES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key1        (key1),
        .auto_en     (auto_en),
        .cmos1_vsync (cmos1_vsync),
        .cmos2_vsync (cmos2_vsync),
        .sel         (sel),
        .out_valid   (out_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .switch_cnt  (switch_cnt)
    );

    // Periodic vsyncs: 24-cycle frames, camera 1 leads camera 2 by half a frame
    int gen_cyc = 0;
    initial forever begin
        @(negedge clk);
        gen_cyc++;
        v1_gen = ((gen_cyc % 24) < 3);
        v2_gen = (((gen_cyc + 12) % 24) < 3);
    end

    // ------------------------------------------------------------------
    // Reference model: phase, waited cycles, frames seen, key-low run length
    // ------------------------------------------------------------------
    bit       model_live = 1'b0;
    int       m_phase, m_wait, m_frames, m_low_run, m_cnt;
    bit       m_sel, m_ov, m_busy, m_err, m_press;
    bit [2:0] hk, h1, h2;   // [0] newest sample; the DUT reacts to [1] vs [2]

    task automatic model_step();
        bit rise1, rise2, sel_rise, key_low, press_seen, auto_req;
        rise1      = h1[1] && !h1[2];
        rise2      = h2[1] && !h2[2];
        key_low    = !hk[1];
        press_seen = m_press;
        sel_rise   = m_sel ? rise1 : rise2;
        if (reset) begin
            m_phase = PH_RUN; m_wait = 0; m_frames = 0; m_low_run = 0; m_cnt = 0;
            m_sel = 0; m_ov = 1; m_busy = 0; m_err = 0; m_press = 0;
            hk = 3'b000; h1 = 3'b000; h2 = 3'b000;
            model_live = 1'b1;
        end else begin
            auto_req = 1'b0;
            if (m_phase == PH_RUN && auto_en && AUTO_FRAMES > 0) begin
                if (sel_rise) begin
                    m_frames++;
                    if (m_frames == AUTO_FRAMES) begin
                        auto_req = 1'b1;
                        m_frames = 0;
                    end
                end
            end else begin
                m_frames = 0;
            end

            case (m_phase)
                PH_RUN: if (press_seen || auto_req) begin
                    m_phase = PH_EOF; m_wait = 0; m_busy = 1;
                end
                PH_EOF: begin
                    if (sel_rise) begin
                        m_phase = PH_SWAP; m_ov = 0;
                    end else if (m_wait + 1 == TIMEOUT) begin
                        m_phase = PH_SWAP; m_ov = 0; m_err = 1;
                    end else begin
                        m_wait++;
                    end
                end
                PH_SWAP: begin
                    m_sel = !m_sel; m_phase = PH_SOF; m_wait = 0;
                end
                default: begin
                    if (sel_rise || m_wait + 1 == TIMEOUT) begin
                        if (!sel_rise) m_err = 1;
                        m_phase = PH_RUN; m_ov = 1; m_busy = 0;
                        m_cnt = (m_cnt + 1) % 256;
                    end else begin
                        m_wait++;
                    end
                end
            endcase

            if (!key_low) m_low_run = 0;
            else if (m_low_run < 1000000) m_low_run++;
            m_press = key_low && (m_low_run == DB_CNT);

            hk = {hk[1:0], key1};
            h1 = {h1[1:0], cmos1_vsync};
            h2 = {h2[1:0], cmos2_vsync};
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (model_live) begin
            n_tests++;
            if (sel !== m_sel || out_valid !== m_ov || busy !== m_busy ||
                timeout_err !== m_err || switch_cnt !== 8'(m_cnt)) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got sel=%b ov=%b busy=%b err=%b cnt=%0d required sel=%b ov=%b busy=%b err=%b cnt=%0d",
                         $time, sel, out_valid, busy, timeout_err, switch_cnt,
                         m_sel, m_ov, m_busy, m_err, m_cnt);
            end
        end
    end

    // Counts sel transitions during the auto-mode run
    bit   mon_en   = 1'b0;
    logic sel_prev = 1'b0;
    int   toggles  = 0;
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (sel !== sel_prev) toggles++;
            sel_prev = sel;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, actual, expected);
        end else begin
            $display("[TB] ok %s = %0d", name, actual);
        end
    endtask

    task automatic wait_busy(input logic level, input int limit, output int waited);
        waited = 0;
        while (busy !== level && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic wait_sel(input logic level, input int limit, output int waited);
        waited = 0;
        while (sel !== level && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int w;
        int busy_hits;
        logic [7:0] cnt0;
        logic [7:0] delta;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_switch_cnt", 32'(switch_cnt), 32'd0);

        // Short press below the debounce length
        key1 = 1'b0;
        repeat (10) @(negedge clk);
        key1 = 1'b1;
        repeat (30) @(negedge clk);
        check("short_press_busy", 32'(busy), 32'd0);
        check("short_press_sel", 32'(sel), 32'd0);

        // Long press: 2 sync + 16 debounce + 1 FSM cycles until busy
        key1 = 1'b0;
        wait_busy(1'b1, 100, w);
        check("press_latency", 32'(w), 32'd19);
        repeat (40 - 19) @(negedge clk);
        key1 = 1'b1;
        check("hold_still_waiting", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        v2_man = 1'b1;
        repeat (2) @(negedge clk);
        check("ov_before_eof", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("ov_drop_at_eof", 32'(out_valid), 32'd0);
        check("sel_hold_in_swap", 32'(sel), 32'd0);
        @(negedge clk);
        check("sel_after_swap", 32'(sel), 32'd1);
        v2_man = 1'b0;
        repeat (46) @(negedge clk);
        v1_man = 1'b1;
        wait_busy(1'b0, 100, w);
        v1_man = 1'b0;
        check("sof_done_in_budget", 32'(busy), 32'd0);
        check("one_switch_cnt", 32'(switch_cnt), 32'd1);
        check("one_switch_sel", 32'(sel), 32'd1);
        check("one_switch_ov", 32'(out_valid), 32'd1);
        check("one_switch_err", 32'(timeout_err), 32'd0);

        // WAIT_SOF timeout with cmos1 silent
        apply_reset();
        key1 = 1'b0;
        wait_busy(1'b1, 100, w);
        key1 = 1'b1;
        v2_man = 1'b1;
        wait_sel(1'b1, 20, w);
        v2_man = 1'b0;
        check("to_reached_sof", 32'(sel), 32'd1);
        wait_busy(1'b0, 200, w);
        check("sof_timeout_cycles", 32'(w), 32'd64);
        check("sof_timeout_err", 32'(timeout_err), 32'd1);
        check("sof_timeout_ov", 32'(out_valid), 32'd1);
        check("sof_timeout_cnt", 32'(switch_cnt), 32'd1);

        // Reset in the middle of WAIT_SOF
        key1 = 1'b0;
        wait_busy(1'b1, 100, w);
        key1 = 1'b1;
        v1_man = 1'b1;
        wait_sel(1'b0, 20, w);
        v1_man = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_sof_busy", 32'(busy), 32'd1);
        apply_reset();
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_ov", 32'(out_valid), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cnt", 32'(switch_cnt), 32'd0);
        check("mid_rst_err", 32'(timeout_err), 32'd0);

        // Edge and WAIT_EOF expiry coincide on the 64th waiting cycle
        key1 = 1'b0;
        wait_busy(1'b1, 100, w);
        key1 = 1'b1;
        repeat (61) @(negedge clk);
        v2_man = 1'b1;
        repeat (2) @(negedge clk);
        check("tie_pre_ov", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("tie_swap_ov", 32'(out_valid), 32'd0);
        check("tie_err_clear", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("tie_sel", 32'(sel), 32'd1);
        v2_man = 1'b0;
        v1_man = 1'b1;
        wait_busy(1'b0, 100, w);
        v1_man = 1'b0;
        check("tie_done_cnt", 32'(switch_cnt), 32'd1);
        check("tie_done_err", 32'(timeout_err), 32'd0);

        // Auto alternation with a key press landing mid-switch
        cnt0     = switch_cnt;
        sel_prev = sel;
        toggles  = 0;
        mon_en   = 1'b1;
        gen_en   = 1'b1;
        auto_en  = 1'b1;
        wait_busy(1'b1, 300, w);
        check("auto_start", 32'(busy), 32'd1);
        key1 = 1'b0;
        repeat (25) @(negedge clk);
        key1 = 1'b1;
        check("press_in_busy_window", 32'(busy), 32'd1);
        wait_busy(1'b0, 100, w);
        busy_hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_hits++;
        end
        check("press_dropped", 32'(busy_hits), 32'd0);
        repeat (400) @(negedge clk);
        mon_en  = 1'b0;
        auto_en = 1'b0;
        delta   = switch_cnt - cnt0;
        check("auto_cnt_vs_toggles", 32'(delta), 32'(toggles));
        check("auto_min_switches", 32'(toggles >= 3), 32'd1);
        gen_en = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t", $time);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
